// File: rtl/fa_bist_checker.sv
// Self-test engine for a 1-bit full adder: sweeps all eight {a,b,cin} vectors,
// samples the adder response after a settle delay and reports error statistics.
module fa_bist_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int NUM_PASSES    = 1,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  state_t          state;
  logic [2:0]      vec;
  logic [SW-1:0]   settle_cnt;
  logic [PW-1:0]   pass_cnt;
  logic            exp_sum;
  logic            exp_carry;
  logic            miss;
  logic [ERR_W-1:0] err_next;

  assign fa_a   = vec[2];
  assign fa_b   = vec[1];
  assign fa_cin = vec[0];

  // Unknown responses fall through to the mismatch default, so they are counted as errors.
  always_comb begin
    exp_sum   = vec[2] ^ vec[1] ^ vec[0];
    exp_carry = (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0]);
    miss      = 1'b1;
    if (fa_sum == exp_sum && fa_carry == exp_carry)
      miss = 1'b0;
    err_next = err_count;
    if (miss && err_count != {ERR_W{1'b1}})
      err_next = err_count + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      vec              <= 3'd0;
      settle_cnt       <= '0;
      pass_cnt         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            err_count        <= '0;
            first_fail_vec   <= 3'd0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            vec              <= 3'd0;
            pass_cnt         <= '0;
            busy             <= 1'b1;
            state            <= APPLY;
          end
        end
        APPLY: begin
          settle_cnt <= SW'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0)
            state <= CHECK;
          else
            settle_cnt <= settle_cnt - 1'b1;
        end
        CHECK: begin
          err_count <= err_next;
          if (miss && !first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
          end
          // Stimulus wraps back to vector 0 only between passes; after the last pass it holds 7.
          if (vec == 3'd7) begin
            if (pass_cnt == PW'(NUM_PASSES - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= (err_next == '0);
              state <= DONE;
            end else begin
              pass_cnt <= pass_cnt + 1'b1;
              vec      <= 3'd0;
              state    <= APPLY;
            end
          end else begin
            vec   <= vec + 3'd1;
            state <= APPLY;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
